// File: rtl/cabac_bad_engine.sv
// rtl/cabac_bad_engine.sv - CABAC arithmetic decoding engine (regular, bypass, terminal bins)
// Define CABAC_BAD_BIN_CNT_EN to add the 32-bit bin_cnt_o output.
module cabac_bad_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_i,
  input  logic [7:0]  bs_data_i,
  input  logic        bs_valid_i,
  output logic        bs_ready_o,
  input  logic        bin_req_valid_i,
  output logic        bin_req_ready_o,
  input  logic [1:0]  bin_mode_i,
  input  logic        mps_i,
  input  logic [31:0] range_lps_lut_i,
  output logic        bin_valid_o,
  output logic        bin_o,
  output logic        bin_eq_lps_o,
  output logic [8:0]  range_o,
  output logic [8:0]  offset_o
`ifdef CABAC_BAD_BIN_CNT_EN
  ,
  output logic [31:0] bin_cnt_o
`endif
);
  typedef enum logic [1:0] {S_INIT, S_IDLE, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [8:0]  range_q, range_d, offset_q, offset_d;
  logic [15:0] buf_q, buf_d, buf_c, diff_sh;
  logic [4:0]  cnt_q, cnt_d, cnt_c, shift_n;
  logic        bin_valid_q, bin_valid_d, bin_q, bin_d, lps_q, lps_d;
  logic        accept;
  logic [7:0]  lut_byte;
  logic [9:0]  rmps, off10, rterm;
  logic [3:0]  lz;

  function automatic logic [3:0] lead_zeros9(input logic [8:0] v);
    lead_zeros9 = 4'd9;
    for (int i = 0; i < 9; i++)
      if (v[i]) lead_zeros9 = 4'(8 - i);
  endfunction

  // Next n buffered bits, right-aligned.
  function automatic logic [15:0] top_bits(input logic [15:0] b, input logic [4:0] n);
    top_bits = (n == 5'd0) ? 16'd0 : (b >> (5'd16 - n));
  endfunction

  always_comb begin
    case (range_q[7:6])
      2'd0:    lut_byte = range_lps_lut_i[31:24];
      2'd1:    lut_byte = range_lps_lut_i[23:16];
      2'd2:    lut_byte = range_lps_lut_i[15:8];
      default: lut_byte = range_lps_lut_i[7:0];
    endcase
  end

  assign bs_ready_o      = (cnt_q <= 5'd8);
  assign bin_req_ready_o = (state_q == S_IDLE) && (cnt_q >= 5'd7);
  assign accept          = bin_req_valid_i && bin_req_ready_o && !init_i;
  assign rmps            = {1'b0, range_q} - {2'b0, lut_byte};
  assign off10           = {offset_q, buf_q[15]};
  assign rterm           = {1'b0, range_q} - 10'd2;
  assign lz              = lead_zeros9({1'b0, lut_byte});
  assign diff_sh         = {6'd0, ({1'b0, offset_q} - rmps)} << lz;

  always_comb begin
    state_d     = state_q;
    range_d     = range_q;
    offset_d    = offset_q;
    bin_valid_d = 1'b0;
    bin_d       = bin_q;
    lps_d       = lps_q;
    shift_n     = 5'd0;
    if (init_i) begin
      state_d  = S_INIT;
      range_d  = 9'd510;
      offset_d = 9'd0;
    end else begin
      case (state_q)
        S_INIT: begin
          range_d = 9'd510;
          if (cnt_q >= 5'd9) begin
            offset_d = buf_q[15:7];
            shift_n  = 5'd9;
            state_d  = S_IDLE;
          end
        end
        S_IDLE: if (accept) begin
          bin_valid_d = (bin_mode_i != 2'd0);
          case (bin_mode_i)
            2'd1: begin
              if ({1'b0, offset_q} >= rmps) begin
                bin_d    = !mps_i;
                lps_d    = 1'b1;
                range_d  = 9'({1'b0, lut_byte} << lz);
                offset_d = 9'(diff_sh | top_bits(buf_q, {1'b0, lz}));
                shift_n  = {1'b0, lz};
              end else begin
                bin_d   = mps_i;
                lps_d   = 1'b0;
                range_d = rmps[8:0];
                if (rmps < 10'd256) begin
                  range_d  = {rmps[7:0], 1'b0};
                  offset_d = {offset_q[7:0], buf_q[15]};
                  shift_n  = 5'd1;
                end
              end
            end
            2'd2: begin
              lps_d   = 1'b0;
              shift_n = 5'd1;
              if (off10 >= {1'b0, range_q}) begin
                bin_d    = 1'b1;
                offset_d = 9'(off10 - {1'b0, range_q});
              end else begin
                bin_d    = 1'b0;
                offset_d = off10[8:0];
              end
            end
            2'd3: begin
              lps_d   = 1'b0;
              range_d = rterm[8:0];
              if ({1'b0, offset_q} >= rterm) begin
                bin_d   = 1'b1;
                state_d = S_DONE;
              end else begin
                bin_d = 1'b0;
                if (rterm < 10'd256) begin
                  range_d  = {rterm[7:0], 1'b0};
                  offset_d = {offset_q[7:0], buf_q[15]};
                  shift_n  = 5'd1;
                end
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end

    // Consume first, then append the incoming byte directly below the remaining bits.
    buf_c = buf_q << shift_n;
    cnt_c = cnt_q - shift_n;
    if (init_i) begin
      buf_c = 16'd0;
      cnt_c = 5'd0;
    end
    buf_d = buf_c;
    cnt_d = cnt_c;
    if (bs_valid_i && bs_ready_o) begin
      buf_d = buf_c | ({bs_data_i, 8'd0} >> cnt_c);
      cnt_d = cnt_c + 5'd8;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      range_q     <= 9'd510;
      offset_q    <= 9'd0;
      buf_q       <= 16'd0;
      cnt_q       <= 5'd0;
      bin_valid_q <= 1'b0;
      bin_q       <= 1'b0;
      lps_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      range_q     <= range_d;
      offset_q    <= offset_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      bin_valid_q <= bin_valid_d;
      bin_q       <= bin_d;
      lps_q       <= lps_d;
    end
  end

  assign bin_valid_o  = bin_valid_q;
  assign bin_o        = bin_q;
  assign bin_eq_lps_o = lps_q;
  assign range_o      = range_q;
  assign offset_o     = offset_q;

`ifdef CABAC_BAD_BIN_CNT_EN
  logic [31:0] bin_cnt_q;
  always_ff @(posedge clk) begin
    if (rst || init_i) bin_cnt_q <= 32'd0;
    else if (bin_valid_d) bin_cnt_q <= bin_cnt_q + 32'd1;
  end
  assign bin_cnt_o = bin_cnt_q;
`endif
endmodule
